lfsr_cfg_loader: RTL
====================

# lfsr_cfg_loader

Serial configuration front-end for the pseudo-random pixel generator. Deserialises a seed or stop word from a 1-bit serial stream and writes it through the generator's `config_rdy`/`config_done` handshake. It then reads the stored word back and re-serialises it for host confirmation. The generator's run enable is gated until both seed and stop words have been loaded successfully.

## Interface
Parameters:
- `PIXEL_BITS`, default 24: configuration word width. Must equal the generator's pixel width.
- `ACK_TIMEOUT`, default 4: maximum number of WAIT_ACK cycles without `config_done_i` before a timeout error.

Ports:
- `clk_i`, input, 1: clock.
- `nreset_i`, input, 1: reset, asynchronous, active-low.
- `start_i`, input, 1: begin a load transaction. Sampled only in IDLE.
- `sel_i`, input, 1: target select, sampled with `start_i`. 0 = seed, 1 = stop.
- `abort_i`, input, 1: cancel the current transaction.
- `sdi_i`, input, 1: serial data in, MSB first.
- `sdi_valid_i`, input, 1: `sdi_i` qualifier.
- `sdo_o`, output, 1: serial readback data, MSB first.
- `sdo_valid_o`, output, 1: `sdo_o` qualifier.
- `config_sel_o`, output, 1: drives generator `config_i`.
- `config_rdy_o`, output, 1: write strobe to generator.
- `config_data_o`, output, PIXEL_BITS: write data to generator.
- `config_done_i`, input, 1: generator write acknowledge.
- `config_data_i`, input, PIXEL_BITS: generator readback (selected by `config_sel_o`).
- `run_i`, input, 1: host run request.
- `lfsr_en_o`, output, 1: generator enable.
- `busy_o`, output, 1: high in any state other than IDLE.
- `seed_loaded_o`, output, 1: sticky; seed word loaded and verified.
- `stop_loaded_o`, output, 1: sticky; stop word loaded and verified.
- `err_o`, output, 2: sticky error code. 00 = none, 01 = ack timeout, 10 = readback mismatch.

## Operation
- FSM states: IDLE, SHIFT, WRITE, WAIT_ACK, READBACK.
- IDLE:
  - On `start_i`: latch `sel_i` into `config_sel_o`, clear the bit counter, clear `err_o`, clear the loaded flag for the selected target, go to SHIFT.
  - `sdi_valid_i` is ignored.
- SHIFT:
  - Each cycle with `sdi_valid_i`=1: `shreg <= {shreg[PIXEL_BITS-2:0], sdi_i}` and the counter increments.
  - On the valid bit with counter == PIXEL_BITS-1, go to WRITE.
  - Cycles with `sdi_valid_i`=0 stall the state with no timeout.
- WRITE:
  - `config_rdy_o`=1 for exactly one cycle; `config_data_o` = `shreg`.
  - Clear the timeout counter, go to WAIT_ACK.
- WAIT_ACK:
  - On `config_done_i`=1: capture `config_data_i` into `shreg` and compare it with the written word.
    - Mismatch: `err_o` <= 10, set no flag, go to IDLE.
    - Match: go to READBACK.
  - After ACK_TIMEOUT cycles without `config_done_i`: `err_o` <= 01, go to IDLE.
- READBACK:
  - Shift out `shreg` MSB first: `sdo_valid_o`=1 for PIXEL_BITS consecutive cycles.
  - After the last bit, set `seed_loaded_o` or `stop_loaded_o` according to `config_sel_o`, go to IDLE.
- `config_sel_o` is held constant from `start_i` acceptance until the next accepted `start_i`.
- `config_data_o` holds its last written value outside WRITE.
- `lfsr_en_o` = `run_i` & `seed_loaded_o` & `stop_loaded_o` & (state==IDLE). It is combinational from registered terms.
- `abort_i`:
  - In any non-IDLE state, go to IDLE next cycle.
  - No flag is set and `err_o` is unchanged.
  - `config_rdy_o` is not asserted if the abort is sampled before WRITE.
  - `abort_i` has priority over all other transitions.
- `start_i` outside IDLE is ignored.

## Timing
- Reset: all outputs 0, state IDLE, `shreg`=0, all counters 0.
- Reference transaction, with `start_i` at cycle 0 and `sdi_valid_i` continuous:
  - SHIFT: cycles 1..PIXEL_BITS.
  - WRITE (`config_rdy_o`=1): cycle PIXEL_BITS+1.
  - WAIT_ACK: the generator returns `config_done_i` at PIXEL_BITS+2, where it is captured.
  - READBACK: `sdo_valid_o` during PIXEL_BITS+3..2·PIXEL_BITS+2.
  - IDLE, flag set, `busy_o`=0: cycle 2·PIXEL_BITS+3.
- `config_done_i` in any state other than WAIT_ACK is ignored.
- Reset mid-transaction: immediate return to IDLE with all flags cleared, so `lfsr_en_o` drops asynchronously.
- A reload of one target while the other is loaded drops `lfsr_en_o` until the reload completes.

## Test plan
- Seed load with PIXEL_BITS=24: shift 0xA5C3F1, ack model with 1-cycle latency.
  - `config_rdy_o` pulses once at cycle 25 with data 0xA5C3F1 and `config_sel_o`=0.
  - `sdo_o` returns 0xA5C3F1 over cycles 27..50.
  - `seed_loaded_o`=1 at cycle 51.
- Seed 0x000001 then stop 0x800000, `run_i`=1: `lfsr_en_o` rises only after `stop_loaded_o`; both flags end at 1.
- Gapped `sdi_valid_i` (every other cycle): the word is still assembled correctly, with WRITE at cycle 48.
- Ack model never responds: after 4 WAIT_ACK cycles, `err_o`=01, `busy_o`=0, no flag set.
- Ack model returns readback 0x123456 for written 0x123457: `err_o`=10, `sdo_valid_o` never asserted.
- `abort_i` at bit 10 of SHIFT: IDLE next cycle, `config_rdy_o` never pulses. A following `start_i` loads correctly.

Source files
------------

// File: rtl/lfsr_cfg_loader.sv
// Serial configuration front-end for the pseudo-random pixel generator: shifts in a
// seed/stop word, writes it through the config handshake, verifies and re-serialises it.
module lfsr_cfg_loader #(
    parameter int PIXEL_BITS  = 24,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    input  logic                  start_i,
    input  logic                  sel_i,
    input  logic                  abort_i,
    input  logic                  sdi_i,
    input  logic                  sdi_valid_i,
    output logic                  sdo_o,
    output logic                  sdo_valid_o,
    output logic                  config_sel_o,
    output logic                  config_rdy_o,
    output logic [PIXEL_BITS-1:0] config_data_o,
    input  logic                  config_done_i,
    input  logic [PIXEL_BITS-1:0] config_data_i,
    input  logic                  run_i,
    output logic                  lfsr_en_o,
    output logic                  busy_o,
    output logic                  seed_loaded_o,
    output logic                  stop_loaded_o,
    output logic [1:0]            err_o
);
    localparam int CNT_W = $clog2(PIXEL_BITS + 1);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PIXEL_BITS - 1);
    localparam logic [TMO_W-1:0] LAST_TMO = TMO_W'(ACK_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SHIFT    = 3'd1;
    localparam logic [2:0] S_WRITE    = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_READBACK = 3'd4;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_MISMATCH = 2'b10;

    logic [2:0]            state_q, state_d;
    logic [PIXEL_BITS-1:0] shreg_q, shreg_d;
    logic [PIXEL_BITS-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  sel_q, sel_d;
    logic                  seed_q, seed_d;
    logic                  stop_q, stop_d;
    logic [1:0]            err_q, err_d;
    logic [PIXEL_BITS-1:0] shift_in;

    assign shift_in = {shreg_q[PIXEL_BITS-2:0], sdi_i};

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        sel_d   = sel_q;
        seed_d  = seed_q;
        stop_d  = stop_q;
        err_d   = err_q;
        // Abort wins over every other transition and leaves flags and error untouched.
        if (abort_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        sel_d   = sel_i;
                        cnt_d   = '0;
                        err_d   = ERR_NONE;
                        state_d = S_SHIFT;
                        if (sel_i) stop_d = 1'b0;
                        else       seed_d = 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (sdi_valid_i) begin
                        shreg_d = shift_in;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BIT) begin
                            wdata_d = shift_in;
                            cnt_d   = '0;
                            state_d = S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    tmo_d   = '0;
                    state_d = S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (config_done_i) begin
                        shreg_d = config_data_i;
                        cnt_d   = '0;
                        if (config_data_i != wdata_q) begin
                            err_d   = ERR_MISMATCH;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_READBACK;
                        end
                    end else if (tmo_q == LAST_TMO) begin
                        err_d   = ERR_TIMEOUT;
                        state_d = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                S_READBACK: begin
                    shreg_d = {shreg_q[PIXEL_BITS-2:0], 1'b0};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                        if (sel_q) stop_d = 1'b1;
                        else       seed_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            sel_q   <= 1'b0;
            seed_q  <= 1'b0;
            stop_q  <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            sel_q   <= sel_d;
            seed_q  <= seed_d;
            stop_q  <= stop_d;
            err_q   <= err_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign config_rdy_o  = (state_q == S_WRITE);
    assign sdo_valid_o   = (state_q == S_READBACK);
    assign sdo_o         = sdo_valid_o & shreg_q[PIXEL_BITS-1];
    assign config_sel_o  = sel_q;
    assign config_data_o = wdata_q;
    assign seed_loaded_o = seed_q;
    assign stop_loaded_o = stop_q;
    assign err_o         = err_q;
    // Enable drops together with the flags on an asynchronous reset.
    assign lfsr_en_o     = run_i & seed_q & stop_q & ~busy_o;

endmodule
